// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Purpose:
//   Moore control FSM for the multi-cycle MIPS datapath. The datapath has one
//   shared memory, one ALU, and IR/A/B/ALUOut/MDR holding registers. Each state
//   is one instruction phase and drives every datapath strobe and mux select.
//   Outputs depend only on the current state. The only exceptions are FETCH and
//   MEM_WRITE, where some strobes follow MEM_READY.
//
// Optional feature (compile-time macro MULTICYCLE_JUMP_EN):
//   Defined   : opcode 000010 (j) goes DECODE -> JUMP(11) -> FETCH.
//   Undefined : opcode 000010 is illegal, and encoding 11 is unused.
//
// Parameters:
//   HALT_ON_ILLEGAL  1: ILLEGAL holds until reset.
//                    0: ILLEGAL lasts one cycle, then FETCH.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset; forces all outputs to 0
//   OPCODE[5:0]  in   IR[31:26], valid from DECODE onward
//   MEM_READY    in   memory completes the current access this cycle
//   PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWRITE, MemREG,
//   RegWRITE, RegDst, ALUSrcA            out  datapath strobes/selects
//   ALUSrcB[1:0]  out  00 B, 01 const 4, 10 sext imm, 11 sext imm<<2
//   PCSource[1:0] out  00 ALU, 01 ALUOut, 10 jump target
//   ALUOP[2:0]    out  000 add, 001 slt, 010 funct, 011 or, 100 and, 110 sub
//   INSTR_DONE    out  one-cycle pulse when an instruction retires
//   ILLEGAL_OP    out  high while in ILLEGAL
//   STATE[3:0]    out  current state encoding (debug)
// -----------------------------------------------------------------------------
module multicycle_control #(
   parameter bit HALT_ON_ILLEGAL = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] OPCODE,
   input  logic       MEM_READY,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       IRWrite,
   output logic       MemRead,
   output logic       MemWRITE,
   output logic       MemREG,
   output logic       RegWRITE,
   output logic       RegDst,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic [2:0] ALUOP,
   output logic       INSTR_DONE,
   output logic       ILLEGAL_OP,
   output logic [3:0] STATE
);

   // Opcodes recognised in DECODE and EXEC_I
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
`ifdef MULTICYCLE_JUMP_EN
   localparam logic [5:0] OP_J     = 6'b000010;
`endif

   // ALU-control encodings
   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SLT   = 3'b001;
   localparam logic [2:0] ALU_FUNCT = 3'b010;
   localparam logic [2:0] ALU_OR    = 3'b011;
   localparam logic [2:0] ALU_AND   = 3'b100;
   localparam logic [2:0] ALU_SUB   = 3'b110;

   // Mux select encodings
   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;
   localparam logic [1:0] PCSRC_ALU  = 2'b00;
   localparam logic [1:0] PCSRC_OUT  = 2'b01;
`ifdef MULTICYCLE_JUMP_EN
   localparam logic [1:0] PCSRC_JMP  = 2'b10;
`endif

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXEC_R    = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_EXEC_I    = 4'd9,
      S_I_WB      = 4'd10,
`ifdef MULTICYCLE_JUMP_EN
      S_JUMP      = 4'd11,
`endif
      S_ILLEGAL   = 4'd12
   } state_e;

   state_e     state_q, state_d;
   logic [5:0] op_q;

   // Raw decoded outputs, before reset gating
   logic       pc_write_s, pc_write_cond_s, iord_s, ir_write_s;
   logic       mem_read_s, mem_write_s, mem_reg_s, reg_write_s;
   logic       reg_dst_s, alu_src_a_s, instr_done_s, illegal_s;
   logic [1:0] alu_src_b_s, pc_source_s;
   logic [2:0] alu_op_s;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // The opcode is captured as the FSM leaves DECODE. Later phases see a
   // stable copy, even if IR or the OPCODE wiring changes afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q <= 6'b000000;
      end else if (state_q == S_DECODE) begin
         op_q <= OPCODE;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_d         = S_FETCH;
      pc_write_s      = 1'b0;
      pc_write_cond_s = 1'b0;
      iord_s          = 1'b0;
      ir_write_s      = 1'b0;
      mem_read_s      = 1'b0;
      mem_write_s     = 1'b0;
      mem_reg_s       = 1'b0;
      reg_write_s     = 1'b0;
      reg_dst_s       = 1'b0;
      alu_src_a_s     = 1'b0;
      alu_src_b_s     = SRCB_B;
      pc_source_s     = PCSRC_ALU;
      alu_op_s        = ALU_ADD;
      instr_done_s    = 1'b0;
      illegal_s       = 1'b0;

      case (state_q)
         S_FETCH: begin
            // PC+4 is computed every fetch cycle. IR and PC commit only in the
            // cycle where the memory actually returns the word.
            mem_read_s  = 1'b1;
            alu_src_b_s = SRCB_FOUR;
            ir_write_s  = MEM_READY;
            pc_write_s  = MEM_READY;
            state_d     = MEM_READY ? S_DECODE : S_FETCH;
         end

         S_DECODE: begin
            // The branch target is computed speculatively into ALUOut.
            alu_src_b_s = SRCB_IMMSH;
            case (OPCODE)
               OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
               OP_RTYPE:                          state_d = S_EXEC_R;
               OP_BEQ:                            state_d = S_BRANCH;
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXEC_I;
`ifdef MULTICYCLE_JUMP_EN
               OP_J:                              state_d = S_JUMP;
`endif
               default:                           state_d = S_ILLEGAL;
            endcase
         end

         S_MEM_ADDR: begin
            alu_src_a_s = 1'b1;
            alu_src_b_s = SRCB_IMM;
            // Only lw and sw reach this state, so anything other than lw is sw.
            state_d     = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         end

         S_MEM_READ: begin
            mem_read_s = 1'b1;
            iord_s     = 1'b1;
            state_d    = MEM_READY ? S_MEM_WB : S_MEM_READ;
         end

         S_MEM_WB: begin
            reg_write_s  = 1'b1;
            mem_reg_s    = 1'b1;
            instr_done_s = 1'b1;
            state_d      = S_FETCH;
         end

         S_MEM_WRITE: begin
            // The write strobe is held for the whole stall. The store retires
            // only in the cycle where memory accepts it.
            mem_write_s  = 1'b1;
            iord_s       = 1'b1;
            instr_done_s = MEM_READY;
            state_d      = MEM_READY ? S_FETCH : S_MEM_WRITE;
         end

         S_EXEC_R: begin
            alu_src_a_s = 1'b1;
            alu_op_s    = ALU_FUNCT;
            state_d     = S_R_WB;
         end

         S_R_WB: begin
            reg_write_s  = 1'b1;
            reg_dst_s    = 1'b1;
            instr_done_s = 1'b1;
            state_d      = S_FETCH;
         end

         S_BRANCH: begin
            // Subtract A-B. The datapath gates PCWriteCond with the zero flag.
            alu_src_a_s     = 1'b1;
            alu_op_s        = ALU_SUB;
            pc_write_cond_s = 1'b1;
            pc_source_s     = PCSRC_OUT;
            instr_done_s    = 1'b1;
            state_d         = S_FETCH;
         end

         S_EXEC_I: begin
            alu_src_a_s = 1'b1;
            alu_src_b_s = SRCB_IMM;
            case (op_q)
               OP_ANDI: alu_op_s = ALU_AND;
               OP_ORI:  alu_op_s = ALU_OR;
               OP_SLTI: alu_op_s = ALU_SLT;
               default: alu_op_s = ALU_ADD;
            endcase
            state_d = S_I_WB;
         end

         S_I_WB: begin
            reg_write_s  = 1'b1;
            instr_done_s = 1'b1;
            state_d      = S_FETCH;
         end

`ifdef MULTICYCLE_JUMP_EN
         S_JUMP: begin
            pc_write_s   = 1'b1;
            pc_source_s  = PCSRC_JMP;
            instr_done_s = 1'b1;
            state_d      = S_FETCH;
         end
`endif

         S_ILLEGAL: begin
            illegal_s = 1'b1;
            state_d   = HALT_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
         end

         // Unused encodings drive nothing and recover to FETCH.
         default: state_d = S_FETCH;
      endcase
   end

   // Reset gates every output combinationally. An abort therefore takes effect
   // immediately, without waiting for a clock edge.
   assign PCWrite     = rst ? 1'b0  : pc_write_s;
   assign PCWriteCond = rst ? 1'b0  : pc_write_cond_s;
   assign IorD        = rst ? 1'b0  : iord_s;
   assign IRWrite     = rst ? 1'b0  : ir_write_s;
   assign MemRead     = rst ? 1'b0  : mem_read_s;
   assign MemWRITE    = rst ? 1'b0  : mem_write_s;
   assign MemREG      = rst ? 1'b0  : mem_reg_s;
   assign RegWRITE    = rst ? 1'b0  : reg_write_s;
   assign RegDst      = rst ? 1'b0  : reg_dst_s;
   assign ALUSrcA     = rst ? 1'b0  : alu_src_a_s;
   assign ALUSrcB     = rst ? 2'b00 : alu_src_b_s;
   assign PCSource    = rst ? 2'b00 : pc_source_s;
   assign ALUOP       = rst ? 3'b000 : alu_op_s;
   assign INSTR_DONE  = rst ? 1'b0  : instr_done_s;
   assign ILLEGAL_OP  = rst ? 1'b0  : illegal_s;
   assign STATE       = rst ? 4'd0  : state_q;

endmodule
